// File: rtl/gold_code_gen.sv
// gold_code_gen: two-register Fibonacci Gold code generator feeding NUM_CH tap-selected channels.
// Define GOLD_EPOCH_EN to build the chip counter and epoch strobe; otherwise Chip_Count/Epoch read 0.
module gold_code_gen #(
  parameter int                  LFSR_LEN = 10,
  parameter logic [LFSR_LEN-1:0] POLY_A   = 10'h204,
  parameter logic [LFSR_LEN-1:0] POLY_B   = 10'h3A6,
  parameter logic [LFSR_LEN-1:0] INIT_A   = 10'h3FF,
  parameter logic [LFSR_LEN-1:0] INIT_B   = 10'h3FF,
  parameter int                  NUM_CH   = 1,
  parameter int                  SELW     = $clog2(LFSR_LEN)
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Enable,
  input  logic                     Load,
  input  logic                     Fill_En_A,
  input  logic                     Fill_En_B,
  input  logic                     New_Fill_A,
  input  logic                     New_Fill_B,
  input  logic [NUM_CH*2*SELW-1:0] Tap_Sel,
  output logic [NUM_CH-1:0]        Gold_Code,
  output logic                     Code_Valid,
  output logic                     Lockup,
  output logic [LFSR_LEN-1:0]      Chip_Count,
  output logic                     Epoch
);

  localparam int CH_W = 2 * SELW;

  logic [LFSR_LEN-1:0] reg_a_q, reg_a_d;
  logic [LFSR_LEN-1:0] reg_b_q, reg_b_d;
  logic [NUM_CH-1:0]   gold_q, gold_d;
  logic                valid_q, valid_d;
  logic                lockup_q, lockup_d;
  logic [NUM_CH-1:0]   chips;
  logic                fb_a;
  logic                fb_b;
  logic                any_fill;
  logic                chip_step;

  function automatic logic tap_bit(input logic [LFSR_LEN-1:0] r,
                                   input logic [SELW-1:0]     sel);
    logic [31:0] idx;
    idx = 32'(sel);
    if (idx < 32'(LFSR_LEN)) begin
      return r[sel];
    end
    return r[0];
  endfunction

  // Chips are formed from the pre-shift state, so they are valid in the same cycle Enable is seen.
  always_comb begin
    chips = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chips[c] = reg_a_q[LFSR_LEN-1]
               ^ tap_bit(reg_b_q, Tap_Sel[c*CH_W +: SELW])
               ^ tap_bit(reg_b_q, Tap_Sel[c*CH_W + SELW +: SELW]);
    end
  end

  always_comb begin
    fb_a      = ^(reg_a_q & POLY_A);
    fb_b      = ^(reg_b_q & POLY_B);
    any_fill  = Fill_En_A | Fill_En_B;
    chip_step = Enable & ~Load & ~any_fill;
  end

  always_comb begin
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    gold_d   = gold_q;
    valid_d  = 1'b0;
    lockup_d = (reg_a_q == '0) || (reg_b_q == '0);

    if (Load) begin
      reg_a_d = INIT_A;
      reg_b_d = INIT_B;
    end else begin
      // A filling register never takes feedback; the other one may still step with Enable.
      if (Fill_En_A) begin
        reg_a_d = {reg_a_q[LFSR_LEN-2:0], New_Fill_A};
      end else if (Enable) begin
        reg_a_d = {reg_a_q[LFSR_LEN-2:0], fb_a};
      end

      if (Fill_En_B) begin
        reg_b_d = {reg_b_q[LFSR_LEN-2:0], New_Fill_B};
      end else if (Enable) begin
        reg_b_d = {reg_b_q[LFSR_LEN-2:0], fb_b};
      end

      if (chip_step) begin
        gold_d  = chips;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      reg_a_q  <= INIT_A;
      reg_b_q  <= INIT_B;
      gold_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      gold_q   <= gold_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
    end
  end

  assign Gold_Code  = gold_q;
  assign Code_Valid = valid_q;
  assign Lockup     = lockup_q;

`ifdef GOLD_EPOCH_EN
  localparam logic [LFSR_LEN-1:0] CNT_LAST = {{(LFSR_LEN-1){1'b1}}, 1'b0};
  localparam logic [LFSR_LEN-1:0] CNT_ONE  = {{(LFSR_LEN-1){1'b0}}, 1'b1};

  logic [LFSR_LEN-1:0] cnt_q, cnt_d;
  logic                started_q, started_d;
  logic                epoch_q, epoch_d;

  // started_q marks that a chip has been emitted since the last clear, so the next one continues the index.
  always_comb begin
    cnt_d     = cnt_q;
    started_d = started_q;
    epoch_d   = 1'b0;
    if (Load || any_fill) begin
      cnt_d     = '0;
      started_d = 1'b0;
    end else if (Enable) begin
      if (!started_q || (cnt_q == CNT_LAST)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
      started_d = 1'b1;
      epoch_d   = (cnt_d == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cnt_q     <= '0;
      started_q <= 1'b0;
      epoch_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      started_q <= started_d;
      epoch_q   <= epoch_d;
    end
  end

  assign Chip_Count = cnt_q;
  assign Epoch      = epoch_q;
`else
  assign Chip_Count = '0;
  assign Epoch      = 1'b0;
`endif

endmodule
